// File: rtl/result_piso.sv
// result_piso: captures an up-to-N x M tile of W-bit results row by row into a
// register file, then streams controller-addressed elements out through an
// FD-deep first-word-fall-through FIFO.
//
// Handshake: an element transfers on a rising edge where dout_valid && dout_ready.
// dout_valid is never withdrawn and dout never changes while dout_valid is high
// and dout_ready is low. dout_valid and full come straight from registers, so
// they have no combinational path from send or dout_ready.
module result_piso #(
  parameter int N  = 16,
  parameter int M  = 16,
  parameter int W  = 32,
  parameter int FD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [7:0]          cfg_n,
  input  logic [7:0]          cfg_m,
  input  logic                cap_valid,
  input  logic [7:0]          cap_row,
  input  logic                cap_last,
  input  logic [M*W-1:0]      cap_data,
  input  logic                send,
  input  logic [7:0]          selO_n,
  input  logic [7:0]          selO_m,
  output logic signed [W-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                full,
  output logic                tile_done,
  output logic                err,
  output logic [1:0]          fsm_state
);

  localparam int NB = (N > 1) ? $clog2(N) : 1;
  localparam int MB = (M > 1) ? $clog2(M) : 1;
  localparam int PB = $clog2(FD);
  localparam logic [8:0]  N_LIM  = 9'(N);
  localparam logic [8:0]  M_LIM  = 9'(M);
  localparam logic [PB:0] FD_CNT = (PB+1)'(FD);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_READY   = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t state, state_next;

  // Tile register file; deliberately not reset so clr can preserve it.
  logic [W-1:0] mem [N][M];

  logic [7:0]    n_lat, m_lat;
  logic          last_pushed;

  // FIFO storage: data plus a tag marking the tile's final element.
  logic [W-1:0]  fifo_data [FD];
  logic          fifo_tag  [FD];
  logic [PB-1:0] wr_ptr, rd_ptr;
  logic [PB:0]   count, count_next;

  // Decoded request qualifiers.
  logic          cap_ok, cap_bad, cap_store;
  logic          send_ok, send_bad;
  logic          in_range, is_last_elem;
  logic          push, pop, done;
  logic [W-1:0]  rd_elem;
  logic [NB-1:0] wr_row;

  assign fsm_state = state;
  assign dout      = dout_valid ? fifo_data[rd_ptr] : '0;

  // Request decode: which capture/send is legal this cycle, and what it reads.
  always_comb begin
    cap_ok       = 1'b0;
    in_range     = (selO_n <= n_lat) && (selO_m <= m_lat);
    is_last_elem = (selO_n == n_lat) && (selO_m == m_lat);
    rd_elem      = '0;
    wr_row       = cap_row[NB-1:0];
    if (cap_valid) begin
      if (state == S_IDLE)    cap_ok = (cap_row <= cfg_n);
      if (state == S_CAPTURE) cap_ok = (cap_row <= n_lat);
    end
    cap_bad   = cap_valid && !cap_ok;
    // Rows beyond the physical array are accepted but have nowhere to go.
    cap_store = cap_ok && ({1'b0, cap_row} < N_LIM);
    send_ok   = send && ((state == S_READY) || (state == S_DRAIN)) &&
                !last_pushed && in_range && !full;
    send_bad  = send && !send_ok;
    if (({1'b0, selO_n} < N_LIM) && ({1'b0, selO_m} < M_LIM))
      rd_elem = mem[selO_n[NB-1:0]][selO_m[MB-1:0]];
    push = send_ok;
    pop  = dout_valid && dout_ready;
    done = pop && fifo_tag[rd_ptr];
  end

  // Next-state logic for the tile lifecycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (cap_ok) state_next = cap_last ? S_READY : S_CAPTURE;
      S_CAPTURE: if (cap_ok && cap_last) state_next = S_READY;
      S_READY:   if (send_ok) state_next = S_DRAIN;
      S_DRAIN:   if (done) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // FIFO occupancy update; push and pop in the same cycle cancel out.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (PB+1)'(1);
      2'b01:   count_next = count - (PB+1)'(1);
      default: count_next = count;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= S_IDLE;
    else if (clr) state <= S_IDLE;
    else          state <= state_next;
  end

  // Control registers: latched tile size, FIFO pointers/flags and pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_lat       <= '0;
      m_lat       <= '0;
      last_pushed <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      dout_valid  <= 1'b0;
      full        <= 1'b0;
      err         <= 1'b0;
      tile_done   <= 1'b0;
    end else if (clr) begin
      n_lat       <= '0;
      m_lat       <= '0;
      last_pushed <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      dout_valid  <= 1'b0;
      full        <= 1'b0;
      err         <= 1'b0;
      tile_done   <= 1'b0;
    end else begin
      if (state == S_IDLE && cap_ok) begin
        n_lat <= cfg_n;
        m_lat <= cfg_m;
      end
      if (done)                      last_pushed <= 1'b0;
      else if (push && is_last_elem) last_pushed <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PB'(1);
      if (pop)  rd_ptr <= rd_ptr + PB'(1);
      count      <= count_next;
      dout_valid <= (count_next != '0);
      full       <= (count_next == FD_CNT);
      err        <= cap_bad || send_bad;
      tile_done  <= done;
    end
  end

  // FIFO storage write on accepted send.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= rd_elem;
      fifo_tag[wr_ptr]  <= is_last_elem;
    end
  end

  // Register file row write on accepted capture.
  always_ff @(posedge clk) begin
    if (cap_store) begin
      for (int j = 0; j < M; j++) mem[wr_row][j] <= cap_data[j*W +: W];
    end
  end

endmodule
